ip_dma_nios2_gen2_0_cpu_ocimem_arb: RTL

IP_DMA_NIOS2_GEN2_0_CPU_OCIMEM_ARB -- requirements
Module: ip_dma_nios2_gen2_0_cpu_ocimem_arb

---
 rtl/ip_dma_nios2_gen2_0_cpu_ocimem_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ip_dma_nios2_gen2_0_cpu_ocimem_arb.sv
// OCI debug-memory arbiter: one single-port RAM shared by the JTAG command register and the Avalon slave.
// Define OCIMEM_DEBUGACCESS_EN to block Avalon writes that arrive with av_debugaccess low.
module ip_dma_nios2_gen2_0_cpu_ocimem_arb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [7:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [31:0] av_writedata,
    input  logic [3:0]  av_byteenable,
    input  logic        av_debugaccess,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic [7:0]  ram_address,
    output logic        ram_wren,
    output logic [3:0]  ram_byteenable,
    output logic [31:0] ram_wrdata,
    input  logic [31:0] ram_rddata,
    output logic [31:0] MonDReg,
    output logic        jtag_busy,
    output logic        jtag_overrun
);
    typedef enum logic [2:0] {
        IDLE, JRD, JRD_CAP, JWR, AVRD, AVRD_CAP, AVWR
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  jaddr;
    logic        pend_vld, pend_wr;
    logic [31:0] pend_data;
    logic        av_last;

    logic        strobe_any, jtag_active, accept, new_op, new_wr;
    logic        jtag_req, av_req, av_wr_ok, contended, grant_j, grant_a;
    logic [7:0]  jaddr_eff;
    logic        op_wr;
    logic [31:0] op_data;
    logic [7:0]  ram_address_nxt;
    logic        ram_wren_nxt;
    logic [3:0]  ram_byteenable_nxt;
    logic [31:0] ram_wrdata_nxt;
    logic        unused_bits;

    assign strobe_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign jtag_active = pend_vld | (state == JRD) | (state == JRD_CAP) | (state == JWR);
    assign accept      = strobe_any & ~jtag_active;
    assign new_op      = accept & (take_action_ocimem_a ? jdo[34] : 1'b1);
    assign new_wr      = ~take_action_ocimem_a & ~take_no_action_ocimem_a;

    // A freshly accepted strobe can be granted in the same IDLE cycle, so it
    // bypasses the pending register and uses the address it is loading.
    assign jaddr_eff = (accept & take_action_ocimem_a) ? jdo[17:10] : jaddr;
    assign jtag_req  = pend_vld | new_op;
    assign op_wr     = pend_vld ? pend_wr : new_wr;
    assign op_data   = pend_vld ? pend_data : jdo[34:3];
    assign av_req    = av_read | av_write;
    assign contended = jtag_req & av_req;

`ifdef OCIMEM_DEBUGACCESS_EN
    assign av_wr_ok = av_debugaccess;
`else
    assign av_wr_ok = 1'b1;
`endif
    assign unused_bits = ^{jdo[37:35], jdo[2:0], av_debugaccess};

    assign jtag_busy      = jtag_active;
    assign av_waitrequest = av_req & ~((state == AVWR) | (state == AVRD_CAP));
    assign av_readdata    = (state == AVRD_CAP) ? ram_rddata : 32'h0;

    always_comb begin
        state_nxt          = state;
        grant_j            = 1'b0;
        grant_a            = 1'b0;
        ram_address_nxt    = ram_address;
        ram_wren_nxt       = 1'b0;
        ram_byteenable_nxt = ram_byteenable;
        ram_wrdata_nxt     = ram_wrdata;
        case (state)
            IDLE: begin
                // av_last only tracks contended grants, so contention alternates
                if (jtag_req && (!av_req || av_last)) begin
                    grant_j   = 1'b1;
                    state_nxt = op_wr ? JWR : JRD;
                end else if (av_req) begin
                    grant_a   = 1'b1;
                    state_nxt = av_write ? AVWR : AVRD;
                end
            end
            JRD:      state_nxt = JRD_CAP;
            JRD_CAP:  state_nxt = IDLE;
            JWR:      state_nxt = IDLE;
            AVRD:     state_nxt = AVRD_CAP;
            AVRD_CAP: state_nxt = IDLE;
            AVWR:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (grant_j) begin
            ram_address_nxt = jaddr_eff;
            if (op_wr) begin
                ram_wren_nxt       = 1'b1;
                ram_byteenable_nxt = 4'hF;
                ram_wrdata_nxt     = op_data;
            end
        end else if (grant_a) begin
            ram_address_nxt = av_address;
            if (av_write) begin
                ram_wren_nxt       = av_wr_ok;
                ram_byteenable_nxt = av_byteenable;
                ram_wrdata_nxt     = av_writedata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ram_address    <= 8'h0;
            ram_wren       <= 1'b0;
            ram_byteenable <= 4'h0;
            ram_wrdata     <= 32'h0;
        end else begin
            state          <= state_nxt;
            ram_address    <= ram_address_nxt;
            ram_wren       <= ram_wren_nxt;
            ram_byteenable <= ram_byteenable_nxt;
            ram_wrdata     <= ram_wrdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jaddr        <= 8'h0;
            pend_vld     <= 1'b0;
            pend_wr      <= 1'b0;
            pend_data    <= 32'h0;
            av_last      <= 1'b1;
            MonDReg      <= 32'h0;
            jtag_overrun <= 1'b0;
        end else begin
            if (accept && take_action_ocimem_a)
                jaddr <= jdo[17:10];
            else if (state == JRD_CAP || state == JWR)
                jaddr <= jaddr + 8'h1;

            if (grant_j) begin
                pend_vld <= 1'b0;
            end else if (new_op) begin
                pend_vld  <= 1'b1;
                pend_wr   <= new_wr;
                pend_data <= jdo[34:3];
            end

            if (contended && grant_j)
                av_last <= 1'b0;
            else if (contended && grant_a)
                av_last <= 1'b1;

            if (state == JRD_CAP)
                MonDReg <= ram_rddata;

            // A dropped strobe flags overrun even when it is take_action_ocimem_a
            if (strobe_any && jtag_active)
                jtag_overrun <= 1'b1;
            else if (take_action_ocimem_a)
                jtag_overrun <= 1'b0;
        end
    end
endmodule
